// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: parametrised N-to-log2(N) priority encoder with a single
// registered valid/ready output stage. MODE selects MSB-first (0), LSB-first
// (1) or round-robin (2) priority.
// Build option: define ONEHOT_CHECK_EN to enable multi-hot detection and the
// saturating err_cnt counter. Otherwise out_multi and err_cnt are tied to 0.
module prio_encoder_rr #(
  parameter int N     = 8,
  parameter int W     = $clog2(N),
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_idx,
  output logic             out_zero,
  output logic             out_multi,
  output logic [CNT_W-1:0] err_cnt
);

  logic         accept;
  logic         in_zero;
  logic [W-1:0] sel_idx;
  logic [W-1:0] ptr_next;

  logic         valid_d, valid_q;
  logic [W-1:0] idx_d, idx_q;
  logic         zero_d, zero_q;
  logic [W-1:0] rr_ptr_d, rr_ptr_q;

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign in_zero   = (in_vec == '0);
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_zero  = zero_q;

  // Priority selection of the winning bit index for the configured mode.
  always_comb begin
    int unsigned j;
    logic        found;
    sel_idx = '0;
    found   = 1'b0;
    j       = 0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < N; i++)
        if (in_vec[i]) sel_idx = W'(i);
    end else if (MODE == 1) begin
      for (int unsigned i = N; i > 0; i--)
        if (in_vec[i-1]) sel_idx = W'(i - 1);
    end else begin
      // Search upward from rr_ptr, wrapping to bit 0; first hit wins.
      for (int unsigned k = 0; k < N; k++) begin
        j = int'(rr_ptr_q) + k;
        if (j >= N) j = j - N;
        if (!found && in_vec[j]) begin
          sel_idx = W'(j);
          found   = 1'b1;
        end
      end
    end
  end

  // Round-robin pointer advance: one past the winner, wrapping at N.
  always_comb begin
    ptr_next = '0;
    if (int'(sel_idx) + 1 != N) ptr_next = W'(int'(sel_idx) + 1);
  end

  // Output stage and pointer next-state from the handshake.
  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    zero_d   = zero_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      valid_d = 1'b1;
      idx_d   = sel_idx;
      zero_d  = in_zero;
      if (MODE == 2 && !in_zero) rr_ptr_d = ptr_next;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      zero_q   <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      zero_q   <= zero_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ONEHOT_CHECK_EN
  logic             in_multi;
  logic             multi_d, multi_q;
  logic [CNT_W-1:0] err_d, err_q;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign in_multi  = |(in_vec & (in_vec - N'(1)));
  assign out_multi = multi_q;
  assign err_cnt   = err_q;

  // Multi-hot flag follows the output register; counter saturates at all-ones.
  always_comb begin
    multi_d = multi_q;
    err_d   = err_q;
    if (accept) begin
      multi_d = in_multi;
      if (in_multi && err_q != '1) err_d = err_q + 1'b1;
    end
  end

  // Multi-hot flag and error counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      multi_q <= 1'b0;
      err_q   <= '0;
    end else begin
      multi_q <= multi_d;
      err_q   <= err_d;
    end
  end
`else
  assign out_multi = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: four instances share the same inputs
// (MODE 0, 1, 2 with CNT_W=8, and MODE 0 with CNT_W=2 for saturation).
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;

  logic       rdy0, rdy1, rdy2, rdy3;
  logic       v0, v1, v2, v3;
  logic [2:0] i0, i1, i2, i3;
  logic       z0, z1, z2, z3;
  logic       m0, m1, m2, m3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt8 = 0;
  int exp_cnt2 = 0;
  bit chk_en;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8), .MODE(0), .CNT_W(8)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_vec(in_vec),
    .out_valid(v0), .out_ready(out_ready), .out_idx(i0), .out_zero(z0),
    .out_multi(m0), .err_cnt(c0));
  prio_encoder_rr #(.N(8), .MODE(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_vec(in_vec),
    .out_valid(v1), .out_ready(out_ready), .out_idx(i1), .out_zero(z1),
    .out_multi(m1), .err_cnt(c1));
  prio_encoder_rr #(.N(8), .MODE(2), .CNT_W(8)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_vec(in_vec),
    .out_valid(v2), .out_ready(out_ready), .out_idx(i2), .out_zero(z2),
    .out_multi(m2), .err_cnt(c2));
  prio_encoder_rr #(.N(8), .MODE(0), .CNT_W(2)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in_vec(in_vec),
    .out_valid(v3), .out_ready(out_ready), .out_idx(i3), .out_zero(z3),
    .out_multi(m3), .err_cnt(c3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector, clock it in (out_ready=1) and update the counter model.
  task automatic send(input logic [7:0] vec);
    in_valid = 1'b1;
    in_vec   = vec;
    tick();
    if (chk_en && $countones(vec) > 1) begin
      exp_cnt8++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
  endtask

  // Compare every output of all instances against hand-computed values.
  task automatic expect_out(input string tag, input int e0, input int e1, input int e2,
                            input bit ez, input bit em);
    bit mm;
    mm = chk_en ? em : 1'b0;
    check({tag, ".valid"}, {28'd0, v0, v1, v2, v3}, 32'hF);
    check({tag, ".idx0"},  32'(i0), 32'(e0));
    check({tag, ".idx1"},  32'(i1), 32'(e1));
    check({tag, ".idx2"},  32'(i2), 32'(e2));
    check({tag, ".idx3"},  32'(i3), 32'(e0));
    check({tag, ".zero"},  {28'd0, z0, z1, z2, z3}, ez ? 32'hF : 32'h0);
    check({tag, ".multi"}, {28'd0, m0, m1, m2, m3}, mm ? 32'hF : 32'h0);
    check({tag, ".cnt8"},  32'(c0), 32'(exp_cnt8));
    check({tag, ".cnt8b"}, 32'(c2), 32'(exp_cnt8));
    check({tag, ".cnt2"},  32'(c3), 32'(exp_cnt2));
  endtask

  initial begin
`ifdef ONEHOT_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst.valid", {28'd0, v0, v1, v2, v3}, 32'h0);
    check("rst.idx",   {20'd0, i0, i1, i2, i3}, 32'h0);
    check("rst.flags", {24'd0, z0, z1, z2, z3, m0, m1, m2, m3}, 32'h0);
    check("rst.cnt",   32'(c0) + 32'(c3), 32'h0);
    check("rst.ready", {28'd0, rdy0, rdy1, rdy2, rdy3}, 32'hF);

    // One-hot walk: same index in every mode; RR pointer walks back to 0.
    for (int i = 0; i < 8; i++) begin
      send(8'(1 << i));
      expect_out($sformatf("walk%0d", i), i, i, i, 1'b0, 1'b0);
    end

    send(8'h00);
    expect_out("zero", 0, 0, 0, 1'b1, 1'b0);

    // RR pointer still 0 -> LSB side wins; pointer moves to 5.
    send(8'b1001_0000);
    expect_out("multi90", 7, 4, 4, 1'b0, 1'b1);

    // 0x80 puts the RR pointer back at 0, then alternate 0,7,0,7.
    send(8'h80);
    expect_out("rr_pre", 7, 7, 7, 1'b0, 1'b0);
    send(8'h81); expect_out("rr_a", 7, 0, 0, 1'b0, 1'b1);
    send(8'h81); expect_out("rr_b", 7, 0, 7, 1'b0, 1'b1);
    send(8'h81); expect_out("rr_c", 7, 0, 0, 1'b0, 1'b1);
    send(8'h81); expect_out("rr_d", 7, 0, 7, 1'b0, 1'b1);
    send(8'h00); expect_out("rr_zero", 0, 0, 0, 1'b1, 1'b0);
    // Pointer unchanged (0) by the zero vector -> bit 0 wins.
    send(8'hFF); expect_out("rr_ff", 7, 0, 0, 1'b0, 1'b1);

    // Backpressure: held result stays, in_ready low, new vector not taken.
    out_ready = 1'b0;
    in_vec    = 8'h04;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d.ready", k), {28'd0, rdy0, rdy1, rdy2, rdy3}, 32'h0);
      tick();
      expect_out($sformatf("bp%0d", k), 7, 0, 0, 1'b0, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", {28'd0, rdy0, rdy1, rdy2, rdy3}, 32'hF);
    send(8'h04);
    expect_out("bp.after", 2, 2, 2, 1'b0, 1'b0);

    // Idle cycle with out_ready=1 drains the output stage.
    in_valid = 1'b0;
    tick();
    check("drain.valid", {28'd0, v0, v1, v2, v3}, 32'h0);

    // Move the RR pointer to 5, then reset with a result held.
    send(8'h10);
    expect_out("pre_rst", 4, 4, 4, 1'b0, 1'b0);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    exp_cnt8 = 0; exp_cnt2 = 0;
    check("midrst.valid", {28'd0, v0, v1, v2, v3}, 32'h0);
    check("midrst.cnt",   32'(c0) + 32'(c2) + 32'(c3), 32'h0);
    send(8'hFF);
    expect_out("post_rst", 7, 0, 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

endmodule
